// File: rtl/sprite_pkg.sv
// Shared sprite bitmap definitions: capture FSM encoding and the 8-bit bitmap address layout
// {slot, row, byte} used by the renderer, tank_bitmap and sprite_capture.
package sprite_pkg;

    localparam int SPRITE_W  = 16;
    localparam int ROW_BYTES = 2;
    localparam int SLOT_W    = 3;
    localparam int ROW_W     = 4;
    localparam int BYTE_W    = 1;
    localparam int ADDR_W    = SLOT_W + ROW_W + BYTE_W;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WAIT_VSTART = 4'd1,
        ST_WAIT_LOAD   = 4'd2,
        ST_WAIT_HSTART = 4'd3,
        ST_DELAY       = 4'd4,
        ST_SAMPLE      = 4'd5,
        ST_STORE_LO    = 4'd6,
        ST_STORE_HI    = 4'd7,
        ST_DONE        = 4'd8
    } capture_state_t;

    function automatic logic [ADDR_W-1:0] bitmap_addr(
        input logic [SLOT_W-1:0] slot,
        input logic [ROW_W-1:0]  row,
        input logic [BYTE_W-1:0] byte_sel
    );
        return {slot, row, byte_sel};
    endfunction

endpackage

// File: rtl/sprite_capture.sv
// Samples a 1-bit pixel stream over a 16x16 window and writes it, two bytes per row,
// into a sprite bitmap slot using the renderer's fetch layout.
module sprite_capture
    import sprite_pkg::*;
#(
    parameter int unsigned PIXEL_DELAY = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm,
    input  logic [2:0] slot,
    input  logic       hmirror,
    input  logic       vmirror,
    input  logic       abort,
    input  logic       vstart,
    input  logic       load,
    input  logic       hstart,
    input  logic       pixel,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] DELAY_LAST = (PIXEL_DELAY == 0) ? 3'd0 : 3'(PIXEL_DELAY - 1);

    capture_state_t        state, state_nxt;
    logic [SLOT_W-1:0]     slot_q;
    logic                  hmirror_q, vmirror_q;
    logic [3:0]            xcount, ycount;
    logic [2:0]            dcount;
    logic [SPRITE_W-1:0]   bits;
    logic [3:0]            sample_idx, row_idx;
    logic                  wr_en_d, done_d;
    logic [7:0]            wr_addr_d, wr_data_d;

    assign sample_idx = hmirror_q ? ~xcount : xcount;
    assign row_idx    = vmirror_q ? ~ycount : ycount;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            done    <= done_d;
        end
    end

    // Output strobes are computed here and registered, so they appear the cycle after their state.
    always_comb begin
        state_nxt = state;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        case (state)
            ST_IDLE:        if (arm)    state_nxt = ST_WAIT_VSTART;
            ST_WAIT_VSTART: if (vstart) state_nxt = ST_WAIT_LOAD;
            ST_WAIT_LOAD:   if (load)   state_nxt = ST_WAIT_HSTART;
            ST_WAIT_HSTART: if (hstart) state_nxt = (PIXEL_DELAY > 0) ? ST_DELAY : ST_SAMPLE;
            ST_DELAY:       if (dcount == DELAY_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE:      if (xcount == 4'd15) state_nxt = ST_STORE_LO;
            ST_STORE_LO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = bitmap_addr(slot_q, row_idx, 1'b0);
                wr_data_d = bits[7:0];
                state_nxt = ST_STORE_HI;
            end
            ST_STORE_HI: begin
                wr_en_d   = 1'b1;
                wr_addr_d = bitmap_addr(slot_q, row_idx, 1'b1);
                wr_data_d = bits[15:8];
                state_nxt = (ycount == 4'd15) ? ST_DONE : ST_WAIT_LOAD;
            end
            ST_DONE: begin
                done_d    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:        state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q    <= '0;
            hmirror_q <= 1'b0;
            vmirror_q <= 1'b0;
            xcount    <= '0;
            ycount    <= '0;
            dcount    <= '0;
            bits      <= '0;
        end else if (!abort) begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        slot_q    <= slot;
                        hmirror_q <= hmirror;
                        vmirror_q <= vmirror;
                        ycount    <= '0;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (load) begin
                        xcount <= '0;
                        bits   <= '0;
                    end
                end
                ST_WAIT_HSTART: dcount <= '0;
                ST_DELAY:       dcount <= dcount + 3'd1;
                ST_SAMPLE: begin
                    bits[sample_idx] <= pixel;
                    xcount           <= xcount + 4'd1;
                end
                ST_STORE_HI: begin
                    if (ycount != 4'd15) ycount <= ycount + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
